// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
//   OPC_BRANCH / OPC_JAL : RV32 major opcodes the predictor recognises
//   cnt_t                : wide container for saturating counters of any width up to CNT_MAX_W
//   cnt_reset_val()      : weakly-not-taken reset value for a counter of a given width
//   sat_inc_dec()        : saturating +1/-1 for a counter of a given width
package bp_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int CNT_MAX_W = 16;

    typedef logic [CNT_MAX_W-1:0] cnt_t;

    // Largest value whose MSB is still 0: weakly not-taken.
    function automatic cnt_t cnt_reset_val(input int width);
        return cnt_t'((32'd1 << (width - 1)) - 32'd1);
    endfunction

    // Move one step toward taken (up=1) or not-taken, clamping at both ends.
    function automatic cnt_t sat_inc_dec(input cnt_t cnt, input logic up, input int width);
        cnt_t top;
        top = cnt_t'((32'd1 << width) - 32'd1);
        if (up)
            return (cnt >= top) ? top : cnt + cnt_t'(1);
        else
            return (cnt == '0) ? '0 : cnt - cnt_t'(1);
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// DEPTH x CNT_BITS table of saturating counters.
//   CLK, RESET_N : clock, async active-low reset (all entries -> weakly not-taken)
//   rd_idx/rd_cnt: combinational read port
//   wr_en/wr_idx/wr_up : synchronous saturating update (+1 when wr_up, else -1)
// A read of the entry being updated in the same cycle returns the old value.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int CNT_BITS = 2
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CNT_BITS-1:0] rd_cnt,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_up
);

    localparam int DEPTH = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] RST_VAL = CNT_BITS'(cnt_reset_val(CNT_BITS));

    logic [CNT_BITS-1:0] mem [DEPTH];
    logic [CNT_BITS-1:0] nxt;

    assign rd_cnt = mem[rd_idx];

    always_comb begin
        nxt = CNT_BITS'(sat_inc_dec(cnt_t'(mem[wr_idx]), wr_up, CNT_BITS));
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
        end else if (wr_en) begin
            mem[wr_idx] <= nxt;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: predicts in ID from a counter table (bimodal or
// gshare), resolves in EX and reports mispredicts with the recovery PC.
//   CLK, RESET_N                          : clock, async active-low reset
//   id_valid/id_opcode/id_pc/id_target    : instruction in ID
//   pred_taken/pred_pc/pred_idx/clear_if  : fetch redirect, index carried to EX, IF/ID flush
//   ex_valid/ex_idx/ex_pred_taken/ex_taken/ex_target/ex_fallthrough : branch resolving in EX
//   mispredict/recover_pc                 : flush IF/ID + ID/EX and reload PC
//   br_count/mp_count                     : perf counters
// Build option: define BP_PERF_CNT_EN to build the perf counters; otherwise
// br_count/mp_count are tied to 0.
// All outputs are forced to 0 while RESET_N is low.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int PC_SIZE   = 12,
    parameter int IDX_BITS  = 6,
    parameter int CNT_BITS  = 2,
    parameter int HIST_BITS = 6,
    parameter int GSHARE    = 0
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                id_valid,
    input  logic [6:0]          id_opcode,
    input  logic [PC_SIZE-1:0]  id_pc,
    input  logic [PC_SIZE-1:0]  id_target,
    output logic                pred_taken,
    output logic [PC_SIZE-1:0]  pred_pc,
    output logic [IDX_BITS-1:0] pred_idx,
    output logic                clear_if,
    input  logic                ex_valid,
    input  logic [IDX_BITS-1:0] ex_idx,
    input  logic                ex_pred_taken,
    input  logic                ex_taken,
    input  logic [PC_SIZE-1:0]  ex_target,
    input  logic [PC_SIZE-1:0]  ex_fallthrough,
    output logic                mispredict,
    output logic [PC_SIZE-1:0]  recover_pc,
    output logic [31:0]         br_count,
    output logic [31:0]         mp_count
);

    logic [HIST_BITS-1:0] ghr;
    logic [HIST_BITS-1:0] ghr_nxt;
    logic [IDX_BITS-1:0]  idx;
    logic [CNT_BITS-1:0]  rd_cnt;
    logic                 pt_raw;
    logic                 mp;
    logic                 pt;

    // Index hash: word-aligned PC bits, optionally XORed with zero-extended history.
    generate
        if (GSHARE != 0) begin : g_gshare
            assign idx = id_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
        end else begin : g_bimodal
            assign idx = id_pc[IDX_BITS+1:2];
        end

        if (HIST_BITS == 1) begin : g_hist1
            assign ghr_nxt = ex_taken;
        end else begin : g_histn
            assign ghr_nxt = {ghr[HIST_BITS-2:0], ex_taken};
        end
    endgenerate

    bp_counter_table #(
        .IDX_BITS (IDX_BITS),
        .CNT_BITS (CNT_BITS)
    ) u_table (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .rd_idx  (idx),
        .rd_cnt  (rd_cnt),
        .wr_en   (ex_valid),
        .wr_idx  (ex_idx),
        .wr_up   (ex_taken)
    );

    always_comb begin
        pt_raw = 1'b0;
        if (id_valid) begin
            case (id_opcode)
                OPC_JAL:    pt_raw = 1'b1;
                OPC_BRANCH: pt_raw = rd_cnt[CNT_BITS-1];
                default:    pt_raw = 1'b0;
            endcase
        end
    end

    // A mispredict flushes ID, so the instruction there must not redirect fetch.
    assign mp = ex_valid & (ex_taken ^ ex_pred_taken);
    assign pt = pt_raw & ~mp;

    assign pred_taken = RESET_N & pt;
    assign pred_pc    = (RESET_N & pt) ? id_target : '0;
    assign pred_idx   = RESET_N ? idx : '0;
    assign clear_if   = RESET_N & (pt | mp);
    assign mispredict = RESET_N & mp;
    assign recover_pc = !RESET_N ? '0 : (ex_taken ? ex_target : ex_fallthrough);

    // History is only advanced by resolved branches, never speculatively.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            ghr <= '0;
        else if (ex_valid)
            ghr <= ghr_nxt;
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] br_q;
    logic [31:0] mp_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            br_q <= '0;
            mp_q <= '0;
        end else begin
            if (ex_valid) br_q <= br_q + 32'd1;
            if (mp)       mp_q <= mp_q + 32'd1;
        end
    end

    assign br_count = RESET_N ? br_q : '0;
    assign mp_count = RESET_N ? mp_q : '0;
`else
    assign br_count = '0;
    assign mp_count = '0;
`endif

    logic unused_bits;
    assign unused_bits = ^{id_pc[PC_SIZE-1:IDX_BITS+2], id_pc[1:0], ghr};

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        id_valid = 1'b0;
    logic [6:0]  id_opcode = '0;
    logic [11:0] id_pc = '0;
    logic [11:0] id_target = 12'h200;
    logic        ex_valid = 1'b0;
    logic [5:0]  ex_idx = '0;
    logic        ex_pred_taken = 1'b0;
    logic        ex_taken = 1'b0;
    logic [11:0] ex_target = 12'h300;
    logic [11:0] ex_fallthrough = 12'h104;

    logic        b_pt, b_clr, b_mp, g_pt, g_clr, g_mp;
    logic [11:0] b_ppc, b_rpc, g_ppc, g_rpc;
    logic [5:0]  b_idx, g_idx;
    logic [31:0] b_brc, b_mpc, g_brc, g_mpc;

    always #5 CLK = ~CLK;

    branch_predictor_bht #(.GSHARE(0)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_pc(id_pc), .id_target(id_target), .pred_taken(b_pt), .pred_pc(b_ppc),
        .pred_idx(b_idx), .clear_if(b_clr), .ex_valid(ex_valid), .ex_idx(ex_idx),
        .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_fallthrough(ex_fallthrough), .mispredict(b_mp), .recover_pc(b_rpc),
        .br_count(b_brc), .mp_count(b_mpc));

    branch_predictor_bht #(.GSHARE(1)) dut_g (
        .CLK(CLK), .RESET_N(RESET_N), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_pc(id_pc), .id_target(id_target), .pred_taken(g_pt), .pred_pc(g_ppc),
        .pred_idx(g_idx), .clear_if(g_clr), .ex_valid(ex_valid), .ex_idx(ex_idx),
        .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_fallthrough(ex_fallthrough), .mispredict(g_mp), .recover_pc(g_rpc),
        .br_count(g_brc), .mp_count(g_mpc));

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: counters as plain integers in 0..3, history as an integer.
    int  m_tbl_b [64];
    int  m_tbl_g [64];
    int  m_ghr;
    int  m_brc, m_mpc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_tbl_b[i] = 1;
            m_tbl_g[i] = 1;
        end
        m_ghr = 0;
        m_brc = 0;
        m_mpc = 0;
    endtask

    function automatic bit m_predict(input int cnt);
        if (!id_valid) return 0;
        if (id_opcode == JAL) return 1;
        if (id_opcode == BR) return cnt >= 2;
        return 0;
    endfunction

    task automatic check_all();
        int  ib, ig;
        bit  mp, ptb, ptg;
        int  rpc, brc, mpc;
        ib  = (int'(id_pc) >> 2) % 64;
        ig  = ib ^ m_ghr;
        mp  = ex_valid && (ex_taken != ex_pred_taken);
        ptb = m_predict(m_tbl_b[ib]) && !mp;
        ptg = m_predict(m_tbl_g[ig]) && !mp;
        rpc = ex_taken ? int'(ex_target) : int'(ex_fallthrough);
`ifdef BP_PERF_CNT_EN
        brc = m_brc;
        mpc = m_mpc;
`else
        brc = 0;
        mpc = 0;
`endif
        if (!RESET_N) begin
            ib = 0; ig = 0; mp = 0; ptb = 0; ptg = 0; rpc = 0; brc = 0; mpc = 0;
        end
        chk("b_pred_taken", 32'(b_pt), 32'(ptb));
        chk("b_pred_pc", 32'(b_ppc), ptb ? 32'(id_target) : 32'd0);
        chk("b_pred_idx", 32'(b_idx), 32'(ib));
        chk("b_clear_if", 32'(b_clr), 32'(ptb | mp));
        chk("b_mispredict", 32'(b_mp), 32'(mp));
        chk("b_recover_pc", 32'(b_rpc), 32'(rpc));
        chk("b_br_count", b_brc, 32'(brc));
        chk("b_mp_count", b_mpc, 32'(mpc));
        chk("g_pred_taken", 32'(g_pt), 32'(ptg));
        chk("g_pred_idx", 32'(g_idx), 32'(ig));
        chk("g_clear_if", 32'(g_clr), 32'(ptg | mp));
        chk("g_mispredict", 32'(g_mp), 32'(mp));
    endtask

    task automatic m_update();
        int v;
        if (RESET_N && ex_valid) begin
            v = m_tbl_b[ex_idx] + (ex_taken ? 1 : -1);
            m_tbl_b[ex_idx] = (v < 0) ? 0 : (v > 3) ? 3 : v;
            v = m_tbl_g[ex_idx] + (ex_taken ? 1 : -1);
            m_tbl_g[ex_idx] = (v < 0) ? 0 : (v > 3) ? 3 : v;
            m_ghr = ((m_ghr << 1) | int'(ex_taken)) % 64;
            m_brc++;
            if (ex_taken != ex_pred_taken) m_mpc++;
        end
    endtask

    // Inputs change on negedge; outputs checked 1 time unit later; model steps on posedge.
    task automatic cyc();
        #1 check_all();
        @(posedge CLK);
        m_update();
        @(negedge CLK);
    endtask

    task automatic drive(input bit idv, input logic [6:0] opc, input logic [11:0] pc,
                         input bit exv, input logic [5:0] exi, input bit expt, input bit ext);
        id_valid = idv; id_opcode = opc; id_pc = pc;
        ex_valid = exv; ex_idx = exi; ex_pred_taken = expt; ex_taken = ext;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        m_reset();
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    typedef struct {
        bit         idv;
        logic [6:0] opc;
        logic [11:0] pc;
        bit         exv;
        logic [5:0] exi;
        bit         expt;
        bit         ext;
        bit         e_pt;
        logic [5:0] e_idx;
        bit         e_clr;
        bit         e_mp;
    } vec_t;

    vec_t vt[20];

    initial begin
        int s;
        int pcs[5];
        int idxs[6];
        logic [6:0] opcs[4];
        pcs  = '{32'h040, 32'h014, 32'h000, 32'h00c, 32'h080};
        idxs = '{0, 1, 2, 3, 5, 16};
        opcs = '{BR, JAL, JALR, 7'h33};

        vt[0]  = '{1, BR,   12'h040, 0, 6'h00, 0, 0, 0, 6'h10, 0, 0};
        vt[1]  = '{0, 7'h0, 12'h040, 1, 6'h10, 0, 1, 0, 6'h10, 1, 1};
        vt[2]  = '{0, 7'h0, 12'h040, 1, 6'h10, 0, 1, 0, 6'h10, 1, 1};
        vt[3]  = '{1, BR,   12'h040, 0, 6'h00, 0, 0, 1, 6'h10, 1, 0};
        for (int i = 4; i < 9; i++)
            vt[i] = '{0, 7'h0, 12'h014, 1, 6'h05, 1, 1, 0, 6'h05, 0, 0};
        vt[9]  = '{0, 7'h0, 12'h014, 1, 6'h05, 1, 0, 0, 6'h05, 1, 1};
        vt[10] = '{1, BR,   12'h014, 0, 6'h00, 0, 0, 1, 6'h05, 1, 0};
        vt[11] = '{0, 7'h0, 12'h014, 1, 6'h05, 1, 0, 0, 6'h05, 1, 1};
        vt[12] = '{1, BR,   12'h014, 0, 6'h00, 0, 0, 0, 6'h05, 0, 0};
        vt[13] = '{1, JAL,  12'h014, 1, 6'h05, 1, 0, 0, 6'h05, 1, 1};
        vt[14] = '{1, JAL,  12'h014, 0, 6'h00, 0, 0, 1, 6'h05, 1, 0};
        vt[15] = '{1, JALR, 12'h040, 0, 6'h00, 0, 0, 0, 6'h10, 0, 0};
        vt[16] = '{0, BR,   12'h040, 0, 6'h00, 0, 0, 0, 6'h10, 0, 0};
        vt[17] = '{1, BR,   12'h040, 1, 6'h10, 1, 0, 0, 6'h10, 1, 1};
        vt[18] = '{1, BR,   12'h040, 1, 6'h10, 0, 0, 1, 6'h10, 1, 0};
        vt[19] = '{1, BR,   12'h040, 0, 6'h00, 0, 0, 0, 6'h10, 0, 0};

        // Outputs held at 0 during reset, even with a JAL and a mispredict presented.
        m_reset();
        drive(1, JAL, 12'h040, 1, 6'h10, 1, 0);
        @(negedge CLK);
        #1 check_all();
        chk("rst_pred_taken", 32'(b_pt), 32'd0);
        chk("rst_mispredict", 32'(b_mp), 32'd0);

        // gshare history: two taken resolves then PC 0x040 hashes to 0x13.
        do_reset();
        drive(0, 7'h0, 12'h000, 1, 6'h01, 1, 1);
        cyc();
        cyc();
        drive(1, BR, 12'h040, 0, 6'h00, 0, 0);
        #1 chk("gshare_idx_0x13", 32'(g_idx), 32'h13);
        cyc();

        // Directed table.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].idv, vt[i].opc, vt[i].pc, vt[i].exv, vt[i].exi, vt[i].expt, vt[i].ext);
            #1;
            chk($sformatf("vec%0d_pred_taken", i), 32'(b_pt), 32'(vt[i].e_pt));
            chk($sformatf("vec%0d_pred_idx", i), 32'(b_idx), 32'(vt[i].e_idx));
            chk($sformatf("vec%0d_clear_if", i), 32'(b_clr), 32'(vt[i].e_clr));
            chk($sformatf("vec%0d_mispredict", i), 32'(b_mp), 32'(vt[i].e_mp));
            if (vt[i].e_pt) chk($sformatf("vec%0d_pred_pc", i), 32'(b_ppc), 32'h200);
            if (vt[i].e_mp) chk($sformatf("vec%0d_recover_pc", i), 32'(b_rpc),
                                vt[i].ext ? 32'h300 : 32'h104);
            cyc();
        end

        // Randomised run against the model.
        for (int c = 0; c < 3000; c++) begin
            s = $urandom_range(0, 9);
            id_valid  = ($urandom_range(0, 7) != 0);
            id_opcode = opcs[$urandom_range(0, 3)];
            id_pc     = (s < 5) ? 12'(pcs[s]) : 12'($urandom);
            id_target = 12'($urandom);
            ex_valid  = ($urandom_range(0, 2) != 0);
            ex_idx    = 6'(idxs[$urandom_range(0, 5)]);
            ex_pred_taken = 1'($urandom);
            ex_taken  = ($urandom_range(0, 3) != 0);
            ex_target = 12'($urandom);
            ex_fallthrough = 12'($urandom);
            cyc();
        end

        // Mid-run async reset with a saturated counter.
        drive(0, 7'h0, 12'h080, 1, 6'h20, 1, 1);
        cyc(); cyc(); cyc();
        drive(1, JAL, 12'h080, 1, 6'h20, 1, 0);
        #2 RESET_N = 1'b0;
        m_reset();
        #1 check_all();
        chk("midrst_br_count", b_brc, 32'd0);
        chk("midrst_mp_count", b_mpc, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        drive(1, BR, 12'h080, 0, 6'h00, 0, 0);
        #1 chk("midrst_first_branch_nt", 32'(b_pt), 32'd0);
        cyc();
        drive(1, BR, 12'h080, 1, 6'h20, 0, 1);
        cyc();
        drive(1, BR, 12'h080, 0, 6'h00, 0, 0);
        #1 chk("midrst_one_taken_predicts", 32'(b_pt), 32'd1);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
